// File: rtl/imex_pkg.sv
// Shared definitions for the imex stream arbiter: default widths, the arbiter
// FSM state encoding and a constant-evaluable clog2 helper.
package imex_pkg;

  localparam int DW_DEF   = 24;          // default pixel word width
  localparam int CW       = DW_DEF / 3;  // per-channel width
  localparam int NREQ_MAX = 8;           // largest supported source count

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Smallest r with 2**r >= v; usable in parameter expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/imex_rr_pick.sv
// Combinational round-robin picker: returns the first requester at or after
// ptr (wrapping) as a one-hot grant, plus an any-request flag.
module imex_rr_pick
  import imex_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic            any
);

  logic [2*NREQ-1:0] dbl_req;
  logic [NREQ-1:0]   rot_req;
  logic [NREQ-1:0]   rot_gnt;
  logic [2*NREQ-1:0] dbl_gnt;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  assign dbl_req = {req, req};
  assign rot_req = NREQ'(dbl_req >> ptr);
  assign rot_gnt = rot_req & (~rot_req + NREQ'(1));
  assign dbl_gnt = {{NREQ{1'b0}}, rot_gnt} << ptr;
  assign gnt     = dbl_gnt[NREQ-1:0] | dbl_gnt[2*NREQ-1:NREQ];
  assign any     = |req;

endmodule

// File: rtl/imex_stream_arb.sv
// Round-robin packet arbiter feeding the single imex pixel datapath.
// One source is granted per packet (or per MAXBURST beats), its beats pass
// through one registered output stage, then the arbiter re-arbitrates.
// Optional build macro IMEX_ARB_STATS_EN adds per-source accepted-beat counters
// on o_stat_beats.
module imex_stream_arb
  import imex_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DW       = DW_DEF,
  parameter int MAXBURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   i_valid,
  input  logic [NREQ*DW-1:0] i_data,
  input  logic [NREQ-1:0]   i_last,
  output logic [NREQ-1:0]   o_ready,
  output logic              o_valid,
  output logic [DW-1:0]     o_data,
  output logic              o_last,
  input  logic              i_ready,
  output logic [NREQ-1:0]   o_grant,
  output logic              o_error
`ifdef IMEX_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0] o_stat_beats
`endif
);

  localparam int PW = (clog2(NREQ) < 1) ? 1 : clog2(NREQ);
  localparam int BW = (clog2(MAXBURST) < 1) ? 1 : clog2(MAXBURST);
  localparam logic [BW-1:0] LAST_CNT = BW'(MAXBURST - 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] grant_q;
  logic [PW-1:0]   gidx_q;
  logic [PW-1:0]   ptr_q;
  logic [BW-1:0]   beat_cnt_q;

  logic [NREQ-1:0] pick_gnt;
  logic            pick_any;
  logic [PW-1:0]   pick_idx;

  logic            take;      // output stage can load a beat this cycle
  logic            accept;    // granted source's beat transfers this cycle
  logic            rel;       // accepted beat ends the grant
  logic            truncate;  // release forced by the burst limit
  logic            sel_valid;
  logic            sel_last;
  logic [DW-1:0]   sel_data;

  imex_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req (i_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .any (pick_any)
  );

  // Encode the picker's one-hot grant into a source index.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) pick_idx = PW'(i);
    end
  end

  assign sel_valid = i_valid[gidx_q];
  assign sel_last  = i_last[gidx_q];
  assign sel_data  = i_data[gidx_q*DW +: DW];
  assign take      = ~o_valid | i_ready;
  assign accept    = (state_q == ST_GRANT) & sel_valid & take;
  assign rel       = accept & (sel_last | (beat_cnt_q == LAST_CNT));
  assign truncate  = rel & ~sel_last;
  assign o_grant   = grant_q;

  // Next-state and per-source accept decode.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    o_ready = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        o_ready = grant_q & {NREQ{take}};
        if (rel) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Grant, round-robin pointer and per-grant beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q    <= '0;
      gidx_q     <= '0;
      ptr_q      <= '0;
      beat_cnt_q <= '0;
    end else if (state_q == ST_IDLE) begin
      if (pick_any) begin
        grant_q <= pick_gnt;
        gidx_q  <= pick_idx;
      end
    end else if (rel) begin
      // Releasing source drops to lowest priority.
      grant_q    <= '0;
      ptr_q      <= (gidx_q == LAST_IDX) ? '0 : gidx_q + PW'(1);
      beat_cnt_q <= '0;
    end else if (accept) begin
      beat_cnt_q <= beat_cnt_q + BW'(1);
    end
  end

  // Registered output stage: load on accept, hold on stall, drain on i_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
      o_error <= 1'b0;
    end else begin
      o_error <= 1'b0;
      if (accept) begin
        o_valid <= 1'b1;
        o_data  <= sel_data;
        o_last  <= rel;
        o_error <= truncate;
      end else if (i_ready) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
    end
  end

`ifdef IMEX_ARB_STATS_EN
  logic [15:0] stat_cnt [NREQ];

  // Per-source saturating count of accepted beats.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: this small register array is reset explicitly; a RAM-backed store could not be cleared this way.
    if (rst) begin
      for (int k = 0; k < NREQ; k++) stat_cnt[k] <= '0;
    end else if (accept && (stat_cnt[gidx_q] != 16'hFFFF)) begin
      stat_cnt[gidx_q] <= stat_cnt[gidx_q] + 16'd1;
    end
  end

  // Flatten the counters onto the stats port.
  always_comb begin
    o_stat_beats = '0;
    for (int k = 0; k < NREQ; k++) o_stat_beats[k*16 +: 16] = stat_cnt[k];
  end
`endif

endmodule

// File: tb/tb_imex_stream_arb.sv
// Self-checking bench for imex_stream_arb: per-source drivers, a scoreboard of
// expected output beats derived from each source's packet stream, a beat
// monitor and a grant monitor. Directed scenarios then a randomized run.
`timescale 1ns/1ps
module tb_imex_stream_arb;

  localparam int NREQ     = 4;
  localparam int DW       = 24;
  localparam int MAXBURST = 16;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    i_valid;
  logic [NREQ*DW-1:0] i_data;
  logic [NREQ-1:0]    i_last;
  logic [NREQ-1:0]    o_ready;
  logic               o_valid;
  logic [DW-1:0]      o_data;
  logic               o_last;
  logic               i_ready;
  logic [NREQ-1:0]    o_grant;
  logic               o_error;
`ifdef IMEX_ARB_STATS_EN
  logic [NREQ*16-1:0] o_stat_beats;
`endif

  imex_stream_arb #(
    .NREQ     (NREQ),
    .DW       (DW),
    .MAXBURST (MAXBURST)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_last  (i_last),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_last  (o_last),
    .i_ready (i_ready),
    .o_grant (o_grant),
    .o_error (o_error)
`ifdef IMEX_ARB_STATS_EN
    ,
    .o_stat_beats (o_stat_beats)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          err;
  } exp_t;

  beat_t src_q [NREQ][$];   // beats each source still has to offer
  exp_t  exp_q [NREQ][$];   // scoreboard: expected output beats per source
  int    run_cnt [NREQ];    // beats since last release, per source
  int    stat_model [NREQ];
  logic [NREQ-1:0] grant_log [$];
  int    gap_log [$];
  int    gap_pct;
  int    beats_out;
  int    err_cnt;
  int    total;
  int    bad;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue one beat for source k and push the response the rules predict:
  // a grant ends on the packet's last beat or after MAXBURST beats.
  task automatic send_beat(input int k, input logic [DW-1:0] d, input logic last);
    beat_t b;
    exp_t  e;
    b.data = d;
    b.last = last;
    src_q[k].push_back(b);
    e.data = d;
    e.last = last || (run_cnt[k] == MAXBURST - 1);
    e.err  = e.last && !last;
    run_cnt[k] = e.last ? 0 : run_cnt[k] + 1;
    exp_q[k].push_back(e);
    if (stat_model[k] < 65535) stat_model[k]++;
  endtask

  // Random packet; the top two data bits carry the source number.
  task automatic send_pkt(input int k, input int len);
    logic [DW-1:0] d;
    for (int i = 0; i < len; i++) begin
      d = DW'($urandom);
      d[DW-1 -: 2] = 2'(k);
      send_beat(k, d, i == len - 1);
    end
  endtask

  function automatic int pending();
    int n;
    n = 0;
    for (int k = 0; k < NREQ; k++) n += src_q[k].size() + exp_q[k].size();
    return n;
  endfunction

  task automatic flush_model();
    for (int k = 0; k < NREQ; k++) begin
      src_q[k].delete();
      exp_q[k].delete();
      run_cnt[k]    = 0;
      stat_model[k] = 0;
    end
    grant_log.delete();
    gap_log.delete();
    i_valid = '0;
    i_last  = '0;
    i_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    flush_model();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((pending() > 0 || o_valid) && n < budget) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check(name, 64'(pending()), 0);
  endtask

  // Source drivers: a presented beat stays until accepted; idle lanes carry junk.
  always begin
    logic [NREQ-1:0] fire;
    @(negedge clk);
    fire = i_valid & o_ready;
    @(posedge clk);
    #1;
    for (int k = 0; k < NREQ; k++) begin
      if (fire[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
      if (fire[k] || !i_valid[k]) begin
        if (src_q[k].size() > 0 && $urandom_range(99) >= gap_pct) begin
          i_valid[k]             = 1'b1;
          i_data[k*DW +: DW]     = src_q[k][0].data;
          i_last[k]              = src_q[k][0].last;
        end else begin
          i_valid[k]             = 1'b0;
          i_data[k*DW +: DW]     = DW'($urandom);
          i_last[k]              = 1'($urandom);
        end
      end
    end
  end

  // Beat monitor: pops the scoreboard whenever a beat transfers downstream.
  always @(negedge clk) begin
    int   k;
    exp_t e;
    logic err_seen_now;
    static logic err_seen = 1'b0;
    static logic in_burst = 1'b0;
    static int   cur_src  = 0;
    if (rst) begin
      err_seen = 1'b0;
      in_burst = 1'b0;
    end else begin
      if (o_error) begin
        err_seen = 1'b1;
        err_cnt++;
        check("err_with_last", {62'b0, o_valid, o_last}, 64'd3);
      end
      if (o_valid && i_ready) begin
        k = int'(o_data[DW-1 -: 2]);
        if (in_burst) check("burst_src", 64'(k), 64'(cur_src));
        if (exp_q[k].size() == 0) begin
          check("unexpected_beat", 64'(exp_q[k].size()), 1);
        end else begin
          e = exp_q[k].pop_front();
          err_seen_now = err_seen;
          check("beat_data", 64'(o_data), 64'(e.data));
          check("beat_last", 64'(o_last), 64'(e.last));
          check("beat_err", 64'(err_seen_now), 64'(e.err));
        end
        err_seen = 1'b0;
        beats_out++;
        in_burst = !o_last;
        cur_src  = k;
      end
    end
  end

  // Grant monitor: grant/ready sanity each cycle, log grants and idle gaps.
  always @(negedge clk) begin
    static int              zero_run = 0;
    static logic [NREQ-1:0] prev_g   = '0;
    if (rst) begin
      zero_run = 0;
      prev_g   = '0;
    end else begin
      check("grant_onehot", 64'($onehot0(o_grant)), 1);
      check("ready_outside_grant", 64'(o_ready & ~o_grant), 0);
      if (o_grant != '0 && prev_g == '0) begin
        grant_log.push_back(o_grant);
        gap_log.push_back(zero_run);
        zero_run = 0;
      end
      if (o_grant == '0) zero_run++;
      prev_g = o_grant;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int b0;
    int e0;
    logic [DW-1:0] hold;
    logic vbefore;

    total     = 0;
    bad       = 0;
    beats_out = 0;
    err_cnt   = 0;
    gap_pct   = 0;
    rst       = 1'b1;
    i_data    = '0;
    flush_model();

    // Reset state.
    #3;
    check("rst_o_valid", 64'(o_valid), 0);
    check("rst_o_data",  64'(o_data),  0);
    check("rst_o_last",  64'(o_last),  0);
    check("rst_o_grant", 64'(o_grant), 0);
    check("rst_o_ready", 64'(o_ready), 0);
    check("rst_o_error", 64'(o_error), 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    // Single source 0, three beats; one bubble plus one cycle of latency.
    send_beat(0, 24'h111111, 1'b0);
    send_beat(0, 24'h222222, 1'b0);
    send_beat(0, 24'h333333, 1'b1);
    n = 0;
    while (!i_valid[0] && n < 10) begin
      @(posedge clk);
      #2;
      n++;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_valid && n < 10);
    check("A_latency", 64'(n), 3);
    wait_drain("A_drain", 100);
    check("A_grant_count", 64'(grant_log.size()), 1);
    if (grant_log.size() > 0) check("A_grant", 64'(grant_log[0]), 64'h1);
    check("A_grant_after", 64'(o_grant), 0);

    // Sources 0 and 2 request continuously with 2-beat packets.
    do_reset();
    for (int p = 0; p < 3; p++) begin
      send_pkt(0, 2);
      send_pkt(2, 2);
    end
    wait_drain("B_drain", 200);
    check("B_grant_count", 64'(grant_log.size()), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < grant_log.size()) begin
        check("B_grant_order", 64'(grant_log[i]), (i % 2 == 0) ? 64'h1 : 64'h4);
        if (i > 0) check("B_idle_gap", 64'(gap_log[i]), 1);
      end
    end

    // Source 1, 20 beats: forced release after 16, then re-grant for 4.
    do_reset();
    e0 = err_cnt;
    send_pkt(1, 20);
    wait_drain("C_drain", 200);
    check("C_errors", 64'(err_cnt - e0), 1);
    check("C_grant_count", 64'(grant_log.size()), 2);
    for (int i = 0; i < 2 && i < grant_log.size(); i++)
      check("C_grant", 64'(grant_log[i]), 64'h2);

    // Downstream stall for 5 cycles mid-packet.
    do_reset();
    b0 = beats_out;
    send_pkt(3, 6);
    n = 0;
    while (beats_out - b0 < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("D_reach_stall", 64'(beats_out - b0), 2);
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    hold = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) hold = o_data;
      else check("D_stall_data", 64'(o_data), 64'(hold));
      check("D_stall_valid", 64'(o_valid), 1);
      check("D_stall_ready", 64'(o_ready), 0);
    end
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    wait_drain("D_drain", 100);
    check("D_beat_count", 64'(beats_out - b0), 6);

    // Reset during beat 2 of 4, then arbitration restarts at source 0.
    do_reset();
    send_pkt(1, 1);
    wait_drain("E_pre_drain", 100);
    b0 = beats_out;
    send_pkt(2, 4);
    n = 0;
    while (beats_out - b0 < 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #2;
    vbefore = o_valid;
    rst = 1'b1;
    #1;
    check("E_busy_before_rst", 64'(vbefore), 1);
    check("E_rst_o_valid", 64'(o_valid), 0);
    check("E_rst_o_data",  64'(o_data),  0);
    check("E_rst_o_last",  64'(o_last),  0);
    check("E_rst_o_grant", 64'(o_grant), 0);
    check("E_rst_o_ready", 64'(o_ready), 0);
    check("E_rst_o_error", 64'(o_error), 0);
    flush_model();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    send_pkt(0, 1);
    send_pkt(1, 1);
    send_pkt(3, 1);
    wait_drain("E_post_drain", 100);
    check("E_grant_count", 64'(grant_log.size()), 3);
    for (int i = 0; i < 3 && i < grant_log.size(); i++)
      check("E_grant_order", 64'(grant_log[i]), (i == 0) ? 64'h1 : (i == 1) ? 64'h2 : 64'h8);

`ifdef IMEX_ARB_STATS_EN
    // Stats: seven beats from source 3 only.
    do_reset();
    send_pkt(3, 7);
    wait_drain("G_drain", 100);
    for (int k = 0; k < NREQ; k++)
      check("G_stat", 64'(o_stat_beats[k*16 +: 16]), 64'(stat_model[k]));
`endif

    // Randomized traffic with input gaps and downstream backpressure.
    gap_pct = 30;
    for (int p = 0; p < 40; p++) begin
      send_pkt(int'($urandom_range(NREQ - 1)), int'($urandom_range(1, 20)));
      repeat ($urandom_range(0, 6)) begin
        @(posedge clk);
        #1;
        i_ready = ($urandom_range(99) < 75);
      end
    end
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    wait_drain("F_drain", 5000);
`ifdef IMEX_ARB_STATS_EN
    for (int k = 0; k < NREQ; k++)
      check("F_stat", 64'(o_stat_beats[k*16 +: 16]), 64'(stat_model[k]));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
